// File: rtl/pea_token_fifo_if.sv
// pea_token_fifo_if: handshake/status bundle for pea_token_fifo.
//   master : producer/consumer side, drives wr_en, wr_data, rd_en and
//            observes rd_data, pop, free_space, empty, full.
//   slave  : the FIFO itself.
// With PEA_FIFO_ERR_EN defined the bundle also carries the sticky
// overflow/underflow flags (FIFO -> user).
interface pea_token_fifo_if #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
);
  // ceil(log2(n)), with a one-entry buffer still given one bit
  localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;

  logic                 wr_en;
  logic [word_size-1:0] wr_data;
  logic                 rd_en;
  logic [word_size-1:0] rd_data;
  logic [AW-1:0]        pop;
  logic [AW-1:0]        free_space;
  logic                 empty;
  logic                 full;
`ifdef PEA_FIFO_ERR_EN
  logic                 overflow;
  logic                 underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, pop, free_space, empty, full
`ifdef PEA_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, pop, free_space, empty, full
`ifdef PEA_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/pea_token_fifo.sv
// pea_token_fifo: single-clock first-word-fall-through token FIFO feeding
// the PEA top level (command, data and result/status instances).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - pea_token_fifo_if.slave: wr_en/wr_data push, rd_en pop,
//          rd_data head token (0 when empty), pop count, free_space,
//          empty, full.
// Optional feature macro PEA_FIFO_ERR_EN adds sticky bus.overflow and
// bus.underflow flags, cleared only by reset.
// Capacity is buffer_size-1 words; one slot always stays unused so the
// count fits in log2(buffer_size) bits.
module pea_token_fifo #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input  logic             clk,
  input  logic             rst,
  pea_token_fifo_if.slave  bus
);
  localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam logic [AW-1:0] MAX_POP = AW'(buffer_size - 1);

  logic [word_size-1:0] mem [buffer_size];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        count;
  logic                 is_empty;
  logic                 is_full;
  logic                 do_wr;
  logic                 do_rd;

  assign is_empty = (count == '0);
  assign is_full  = (count == MAX_POP);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside an accepted read.
  assign do_rd = bus.rd_en & ~is_empty;
  assign do_wr = bus.wr_en & (~is_full | do_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + AW'(1);
        2'b01:   count <= count - AW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared on reset; reset-gated so a write issued in a
  // reset cycle leaves no trace either.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[wr_ptr] <= bus.wr_data;
  end

  always_comb begin
    bus.rd_data    = is_empty ? '0 : mem[rd_ptr];
    bus.pop        = count;
    bus.free_space = MAX_POP - count;
    bus.empty      = is_empty;
    bus.full       = is_full;
  end

`ifdef PEA_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en & is_full & ~bus.rd_en) overflow_q  <= 1'b1;
      if (bus.rd_en & is_empty)             underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_pea_token_fifo.sv
// tb_pea_token_fifo: directed scoreboard bench for pea_token_fifo with
// buffer_size=8, word_size=16. Stimulus pushes each token it expects to
// be accepted into a queue; a monitor pops and compares rd_data whenever
// the FIFO presents a head that is being read.
module tb_pea_token_fifo;
  localparam int WS = 16;
  localparam int BS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [WS-1:0] exp_q [$];

  always #5 clk = ~clk;

  pea_token_fifo_if #(.word_size(WS), .buffer_size(BS)) bus ();

  pea_token_fifo #(.word_size(WS), .buffer_size(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: head token is consumed at the next edge when rd_en & ~empty.
  always @(negedge clk) begin
    if (rst && bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no token", bus.rd_data);
      end else begin
        chk("rd_data_order", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic w, input logic [WS-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic status(input string tag, input int p, input logic e, input logic f,
                        input logic [WS-1:0] head);
    chk({tag, "_pop"},   32'(bus.pop), 32'(p));
    chk({tag, "_free"},  32'(bus.free_space), 32'(7 - p));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(e));
    chk({tag, "_full"},  32'(bus.full), 32'(f));
    chk({tag, "_head"},  32'(bus.rd_data), 32'(head));
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    status("reset", 0, 1'b1, 1'b0, 16'h0000);
`ifdef PEA_FIFO_ERR_EN
    chk("reset_ovf", 32'(bus.overflow), 0);
    chk("reset_udf", 32'(bus.underflow), 0);
`endif

    // Read on empty is ignored
    cyc(1'b0, 16'h0, 1'b1);
    status("rd_empty", 0, 1'b1, 1'b0, 16'h0000);
`ifdef PEA_FIFO_ERR_EN
    chk("udf_set", 32'(bus.underflow), 1);
`endif

    // Fill with 1..7; head is 1 from the first write edge
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(WS'(i));
      cyc(1'b1, WS'(i), 1'b0);
      status($sformatf("fill%0d", i), i, 1'b0, (i == 7), 16'h0001);
    end

    // Write while full, no read: dropped
    cyc(1'b1, 16'hDEAD, 1'b0);
    status("ovf_write", 7, 1'b0, 1'b1, 16'h0001);
`ifdef PEA_FIFO_ERR_EN
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("udf_sticky", 32'(bus.underflow), 1);
`endif

    // Simultaneous read/write while full
    exp_q.push_back(16'h0008);
    cyc(1'b1, 16'h0008, 1'b1);
    status("full_rw", 7, 1'b0, 1'b1, 16'h0002);

    // Drain to pop=3 (reads 2..5)
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);
    status("drain3", 3, 1'b0, 1'b0, 16'h0006);

    // Wrap: 20 write/read pairs at pop=3
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(WS'(16'h1000 + i));
      cyc(1'b1, WS'(16'h1000 + i), 1'b1);
      chk($sformatf("wrap%0d_pop", i), 32'(bus.pop), 3);
    end
    status("wrap_end", 3, 1'b0, 1'b0, 16'h1011);

    // Drain completely
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
    status("drained", 0, 1'b1, 1'b0, 16'h0000);

    // Simultaneous read/write on empty: only the write lands
    exp_q.push_back(16'hBEEF);
    cyc(1'b1, 16'hBEEF, 1'b1);
    status("empty_rw", 1, 1'b0, 1'b0, 16'hBEEF);

    // Build to pop=5, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(WS'(16'h2000 + i));
      cyc(1'b1, WS'(16'h2000 + i), 1'b0);
    end
    status("pre_rst", 5, 1'b0, 1'b0, 16'hBEEF);
    rst = 1'b0;
    cyc(1'b1, 16'h5555, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    status("mid_rst", 0, 1'b1, 1'b0, 16'h0000);
`ifdef PEA_FIFO_ERR_EN
    chk("rst_ovf_clr", 32'(bus.overflow), 0);
    chk("rst_udf_clr", 32'(bus.underflow), 0);
`endif

    // Fresh order after reset
    exp_q.push_back(16'h00A1);
    cyc(1'b1, 16'h00A1, 1'b0);
    exp_q.push_back(16'h00A2);
    cyc(1'b1, 16'h00A2, 1'b0);
    status("post_rst", 2, 1'b0, 1'b0, 16'h00A1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    status("final", 0, 1'b1, 1'b0, 16'h0000);
    chk("queue_left", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pea_token_fifo.md
Name: pea_token_fifo

Overview:
- Synchronous single-clock token FIFO that sits directly upstream of the PEA top-level module.
- Instantiated three ways:
  - Command Input FIFO: drives command_in/command_pop, consumes command_rd_en.
  - Data Input FIFO: drives data_in/data_pop, consumes data_rd_en.
  - Result/Status Output FIFO, with word width doubled: drives result_free_space/status_free_space, consumes the PEA wr_en signals.
- Provides first-word-fall-through reads plus population and free-space counts. The PEA enable logic uses these counts to decide whether a firing may start.

Parameters:
- word_size, 16, bit width of each stored token (set to 32 for result/status instances).
- buffer_size, 1024, RAM depth in words; must be a power of two, at least 2. Usable capacity is buffer_size-1 words.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset. Sampled on posedge clk; 0 resets the block.
- wr_en  input  1  write request; pushes wr_data this cycle.
- wr_data  input  word_size  token to push.
- rd_en  input  1  read request; pops the head token this cycle.
- rd_data  output  word_size  current head token (FWFT); 0 when empty.
- pop  output  log2(buffer_size)  number of stored words.
- free_space  output  log2(buffer_size)  buffer_size-1-pop.
- empty  output  1  pop==0.
- full  output  1  pop==buffer_size-1.

Behaviour:
- log2 follows the codebase function: ceil(log2(value)), with log2(1)=1.
  - AW=log2(buffer_size) sets the pointer width and the count width.
- Storage:
  - mem[buffer_size] of word_size bits.
  - wr_ptr and rd_ptr are AW bits wide and wrap naturally modulo buffer_size.
  - One slot is always left unused, so pop never exceeds 2^AW-1 and fits in AW bits.
- Reset (rst==0 at posedge clk):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: pop=0, free_space=buffer_size-1, empty=1, full=0, rd_data=0.
  - mem contents are not cleared.
  - Reset takes priority over any wr_en/rd_en in the same cycle. A reset mid-stream discards all stored tokens.
- Write acceptance: do_wr = wr_en & (~full | do_rd).
  - On do_wr: mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1.
- Read acceptance: do_rd = rd_en & ~empty.
  - On do_rd: rd_ptr<=rd_ptr+1.
- Count update each cycle:
  - count <= count + do_wr - do_rd.
  - Simultaneous accepted read and write leave count unchanged.
- Outputs:
  - pop, free_space, empty and full are derived combinationally from the registered count.
  - All four update the cycle after the accepted operation.
- rd_data:
  - Equals mem[rd_ptr] combinationally when ~empty, else 0.
  - Latency:
    - A word written at edge t is visible on rd_data from edge t onward when the FIFO was empty.
    - empty deasserts at the same edge.
  - PEA samples rd_data in the same cycle it asserts rd_en; the next head appears after that edge.
- Boundary conditions:
  - Write when full, no read: ignored. count, pointers and mem are unchanged.
  - Write when full with a read: both accepted; count stays at buffer_size-1.
  - Read when empty: ignored. Pointers are unchanged and rd_data stays 0.
  - Read and write in the same cycle when empty: only the write is accepted. count becomes 1 and the new word appears on rd_data.
  - Pointer wrap from buffer_size-1 to 0 must be seamless: no lost words and no count glitch.

Optional Feature:
- Macro: PEA_FIFO_ERR_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky; set by wr_en & full & ~rd_en.
  - underflow (1 bit): sticky; set by rd_en & empty.
- Both clear only on reset and feed the PEA status error path.
- When undefined, the ports and logic are absent and ignored requests are silently dropped.

Test Plan:
- Reset with buffer_size=8, then fill: 7 writes of 0x0001..0x0007 -> pop counts 1..7, free_space 6..0. full=1 after the 7th write. rd_data=0x0001 from the first write edge.
- 8th write of 0xDEAD while full -> pop stays 7. The first 7 reads return 0x0001..0x0007 in order and 0xDEAD never appears. With PEA_FIFO_ERR_EN, overflow=1.
- Read on empty after reset -> rd_data=0 and pop=0. With PEA_FIFO_ERR_EN, underflow=1 and it remains set until rst=0.
- Wrap test: 20 interleaved write/read pairs of 0x1000+i at pop=3 -> pop stays 3 and tokens emerge in order across pointer wrap.
- Simultaneous rd_en/wr_en when full (pop=7) -> head advances, new word is queued, pop stays 7. Simultaneous on empty -> pop=1 and rd_data=new word.
- rst=0 pulse mid-stream at pop=5 -> next cycle pop=0, empty=1, free_space=7, rd_data=0. Later writes restart from fresh order.
